// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, broadcast struct and functional-unit indices
package cdb_arbiter_pkg;
  localparam int NREQ = 4;
  localparam int TAG_W = 5;
  localparam int XLEN = 32;
  localparam int FU_ALU = 0;
  localparam int FU_BR = 1;
  localparam int FU_LD = 2;
  localparam int FU_ST = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] value;
  } cdb_t;
endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int j;
  // scanning farthest-first lets the slot closest to ptr overwrite the rest
  always_comb begin
    grant = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = cdb_arbiter_pkg::NREQ,
  parameter int TAG_W = cdb_arbiter_pkg::TAG_W,
  parameter int XLEN = cdb_arbiter_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ*XLEN-1:0]  req_value,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [XLEN-1:0]       cdb_value,
  output logic                  err_tag0
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, g;
  logic [NREQ-1:0] eligible, zero_tag;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0] sel_value;
  logic transfer;
  cdb_t cdb_q;
  always_comb begin
    eligible = '0;
    zero_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      zero_tag[i] = req_valid[i] && (req_tag[i*TAG_W +: TAG_W] == '0);
      eligible[i] = req_valid[i] && !zero_tag[i] && !flush && rst_n;
    end
  end
  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (.req(eligible), .ptr(ptr), .grant(req_ready));
  always_comb begin
    g = '0;
    sel_tag = '0;
    sel_value = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        g = PW'(i);
        sel_tag = req_tag[i*TAG_W +: TAG_W];
        sel_value = req_value[i*XLEN +: XLEN];
      end
  end
  assign transfer = |req_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cdb_q <= '0;
      ptr <= '0;
      err_tag0 <= 1'b0;
    end else begin
      cdb_q.valid <= transfer;
      if (transfer) begin
        cdb_q.tag <= sel_tag;
        cdb_q.value <= sel_value;
        ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
      if (!flush && |zero_tag) err_tag0 <= 1'b1;
    end
  assign cdb_valid = cdb_q.valid;
  assign cdb_tag = cdb_q.tag;
  assign cdb_value = cdb_q.value;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of grant order, latency, flush, tag-0 and reset
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic [NREQ*XLEN-1:0] req_value = '0;
  logic [NREQ-1:0] req_ready;
  logic flush = 1'b0;
  logic cdb_valid, err_tag0;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_value;
  int tests = 0, fails = 0;
  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .req_ready(req_ready), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .err_tag0(err_tag0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] val);
    req_valid[i] = v;
    req_tag[i*TAG_W +: TAG_W] = t;
    req_value[i*XLEN +: XLEN] = val;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    set_slot(FU_ALU, 1'b1, 5'd3, 32'h1111);
    #12;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    chk("rst_value", 64'(cdb_value), 64'h0);
    chk("rst_err", 64'(err_tag0), 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'h0);
    req_valid = '0;
    #5 rst_n = 1'b1;
    tick();
    // single request on load slot
    set_slot(FU_LD, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_tag", 64'(cdb_tag), 64'd5);
    chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
    chk("single_ptr", 64'(dut.ptr), 64'd3);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'h0);
    chk("idle_tag_hold", 64'(cdb_tag), 64'd5);
    chk("idle_value_hold", 64'(cdb_value), 64'hDEADBEEF);
    // ptr 3 -> 1 via a grant on slot 0, then rotation skip
    set_slot(FU_ALU, 1'b1, 5'd6, 32'h6);
    tick();
    req_valid = '0;
    chk("skip_setup_ptr", 64'(dut.ptr), 64'd1);
    set_slot(FU_ALU, 1'b1, 5'd10, 32'hA0);
    set_slot(FU_ST, 1'b1, 5'd13, 32'hD3);
    #1 chk("skip_first", 64'(req_ready), 64'b1000);
    tick();
    req_valid[FU_ST] = 1'b0;
    #1 chk("skip_second", 64'(req_ready), 64'b0001);
    chk("skip_tag3", 64'(cdb_tag), 64'd13);
    tick();
    req_valid = '0;
    chk("skip_tag0", 64'(cdb_tag), 64'd10);
    chk("skip_ptr", 64'(dut.ptr), 64'd1);
    // bring ptr to 0 via slot 3
    set_slot(FU_ST, 1'b1, 5'd4, 32'h4);
    tick();
    req_valid = '0;
    chk("full_setup_ptr", 64'(dut.ptr), 64'd0);
    for (int i = 0; i < NREQ; i++) set_slot(i, 1'b1, TAG_W'(i + 1), XLEN'(32'h100 + i));
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("full_ready%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      tick();
      chk($sformatf("full_valid%0d", k), 64'(cdb_valid), 64'h1);
      chk($sformatf("full_tag%0d", k), 64'(cdb_tag), 64'(k % 4 + 1));
      chk($sformatf("full_value%0d", k), 64'(cdb_value), 64'(32'h100 + k % 4));
    end
    req_valid = '0;
    // flush blocks grant, ptr held; then grant resumes
    set_slot(FU_ALU, 1'b1, 5'd7, 32'h77);
    flush = 1'b1;
    #1 chk("flush_ready", 64'(req_ready), 64'h0);
    tick();
    chk("flush_valid", 64'(cdb_valid), 64'h0);
    chk("flush_ptr", 64'(dut.ptr), 64'd0);
    flush = 1'b0;
    #1 chk("postflush_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    flush = 1'b1;
    #1 chk("late_flush_valid", 64'(cdb_valid), 64'h1);
    chk("late_flush_tag", 64'(cdb_tag), 64'd7);
    tick();
    flush = 1'b0;
    chk("late_flush_after", 64'(cdb_valid), 64'h0);
    chk("late_flush_ptr", 64'(dut.ptr), 64'd1);
    // tag 0 on the branch slot is never granted and sets the sticky flag
    set_slot(FU_BR, 1'b1, 5'd0, 32'hBAD);
    set_slot(FU_LD, 1'b1, 5'd9, 32'h99);
    #1 chk("tag0_ready", 64'(req_ready), 64'b0100);
    chk("tag0_err_before", 64'(err_tag0), 64'h0);
    tick();
    req_valid[FU_LD] = 1'b0;
    chk("tag0_err", 64'(err_tag0), 64'h1);
    chk("tag0_cdb_tag", 64'(cdb_tag), 64'd9);
    #1 chk("tag0_alone_ready", 64'(req_ready), 64'h0);
    tick();
    req_valid = '0;
    chk("tag0_alone_valid", 64'(cdb_valid), 64'h0);
    tick();
    chk("tag0_sticky", 64'(err_tag0), 64'h1);
    // asynchronous reset mid-broadcast
    set_slot(FU_ST, 1'b1, 5'd21, 32'h5555);
    tick();
    req_valid = '0;
    chk("ar_pre_valid", 64'(cdb_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("ar_valid", 64'(cdb_valid), 64'h0);
    chk("ar_err", 64'(err_tag0), 64'h0);
    chk("ar_tag", 64'(cdb_tag), 64'h0);
    tick();
    #3 rst_n = 1'b1;
    chk("ar_ptr", 64'(dut.ptr), 64'h0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
